// File: rtl/uart_rx_irq_pkg.sv
// Shared types and constants for the uart_rx_irq peripheral.
// UART_RX_PARITY_EN adds the even-parity PARITY receiver state.
package uart_rx_irq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop
    } type_uart_rx_state_e;

    localparam logic [3:0] UART_RXDATA = 4'h0;
    localparam logic [3:0] UART_STATUS = 4'h4;
    localparam logic [3:0] UART_CTRL   = 4'h8;
    localparam logic [3:0] UART_DIV    = 4'hC;

    // Interrupt cause number, matching mcause 0x80000010.
    localparam int unsigned UART_IRQ_CODE = 16;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous RX FIFO with extra-MSB pointers for full/empty detection.
// Push while full is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      head_q, tail_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (head_q == tail_q);
    assign full    = (head_q[AW] != tail_q[AW]) && (head_q[AW-1:0] == tail_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[head_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (do_push) tail_q <= tail_q + 1'b1;
            if (do_pop)  head_q <= head_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[tail_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx_irq.sv
// Memory-mapped 8N1 UART receiver with RX FIFO and one-cycle interrupt pulse.
// Define UART_RX_PARITY_EN for an even-parity bit and STATUS[4] parity error.
module uart_rx_irq
    import uart_rx_irq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RST    = 16'd27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    input  logic        bus_sel,
    input  logic        bus_wr,
    input  logic        bus_rd,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        exc_uart
);

    type_uart_rx_state_e state_q, state_d;

    logic        rx_s1_q, rx_s2_q;
    logic [1:0]  ctrl_q;
    logic [15:0] div_q, div_eff, tick_cnt_q, tick_cnt_d;
    logic [3:0]  samp_cnt_q, samp_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        ovr_q, frm_q, par_q, irq_q;
    logic        tick, push, frm_set, par_set;
    logic        wr_en, pop, status_w1c;
    logic        fifo_full, fifo_empty, push_ok;
    logic [7:0]  fifo_rdata;
    logic        unused_bits;

    assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:16]};

    assign wr_en      = bus_sel && bus_wr;
    assign status_w1c = wr_en && (bus_addr[3:2] == UART_STATUS[3:2]);
    assign pop        = bus_sel && bus_rd && (bus_addr[3:2] == UART_RXDATA[3:2]);
    assign push_ok    = push && (!fifo_full || (pop && !fifo_empty));

    assign div_eff    = (div_q == 16'd0) ? 16'd1 : div_q;
    assign tick       = (tick_cnt_q == div_eff - 16'd1);
    assign tick_cnt_d = (wr_en && bus_addr[3:2] == UART_DIV[3:2]) ? 16'd0 :
                        tick ? 16'd0 : tick_cnt_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        samp_cnt_d = tick ? samp_cnt_q + 4'd1 : samp_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        push       = 1'b0;
        frm_set    = 1'b0;
        par_set    = 1'b0;
        if (!ctrl_q[0]) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!rx_s2_q) begin
                        state_d    = StStart;
                        samp_cnt_d = 4'd0;
                    end
                end
                // Mid-start-bit recheck rejects glitches shorter than half a bit.
                StStart: begin
                    if (tick && samp_cnt_q == 4'd7) begin
                        if (!rx_s2_q) begin
                            state_d    = StData;
                            samp_cnt_d = 4'd0;
                            bit_idx_d  = 3'd0;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                StData: begin
                    if (tick && samp_cnt_q == 4'd15) begin
                        shift_d   = {rx_s2_q, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                        if (bit_idx_q == 3'd7) state_d = StParity;
`else
                        if (bit_idx_q == 3'd7) state_d = StStop;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (tick && samp_cnt_q == 4'd15) begin
                        par_set = (rx_s2_q != ^shift_q);
                        state_d = StStop;
                    end
                end
`endif
                StStop: begin
                    if (tick && samp_cnt_q == 4'd15) begin
                        push    = rx_s2_q;
                        frm_set = !rx_s2_q;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            state_q    <= StIdle;
            ctrl_q     <= 2'b00;
            div_q      <= DIV_RST;
            tick_cnt_q <= 16'd0;
            samp_cnt_q <= 4'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            ovr_q      <= 1'b0;
            frm_q      <= 1'b0;
            par_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            rx_s1_q    <= uart_rx;
            rx_s2_q    <= rx_s1_q;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            if (wr_en && bus_addr[3:2] == UART_CTRL[3:2]) ctrl_q <= bus_wdata[1:0];
            if (wr_en && bus_addr[3:2] == UART_DIV[3:2])  div_q  <= bus_wdata[15:0];
            // A same-cycle set wins over the write-1-to-clear.
            ovr_q <= (ovr_q && !(status_w1c && bus_wdata[2])) || (push && !push_ok);
            frm_q <= (frm_q && !(status_w1c && bus_wdata[3])) || frm_set;
            par_q <= (par_q && !(status_w1c && bus_wdata[4])) || par_set;
            irq_q <= push_ok && ctrl_q[1];
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (shift_q),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        bus_rdata = 32'd0;
        case (bus_addr[3:2])
            UART_RXDATA[3:2]: bus_rdata = {24'd0, fifo_empty ? 8'd0 : fifo_rdata};
            UART_STATUS[3:2]: bus_rdata = {27'd0, par_q, frm_q, ovr_q, fifo_full, !fifo_empty};
            UART_CTRL[3:2]:   bus_rdata = {30'd0, ctrl_q};
            default:          bus_rdata = {16'd0, div_q};
        endcase
    end

    assign exc_uart = irq_q;

endmodule

// File: doc/uart_rx_irq.md
# uart_rx_irq

Memory-mapped UART receiver peripheral that deserialises 8N1 frames from the `uart_rx` pin into an RX FIFO. It raises the `exc_uart` interrupt consumed by the machine-mode CSR file, where it is latched into `mip[16]`. It sits on the data-memory bus beside the processor's load/store unit. The CPU drains bytes through register reads, and each read of RXDATA pops the FIFO.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: RX FIFO entries; power of two, ≥2.
- `DIV_RST`, 27: reset value of the 16× oversample divisor (50 MHz / 115200 / 16).

Ports:
- `clk`  in  1  system clock; the block has one clock.
- `rst`  in  1  synchronous, active-low reset.
- `uart_rx`  in  1  asynchronous serial input; idles high.
- `bus_sel`  in  1  peripheral selected this cycle.
- `bus_wr`  in  1  write strobe; qualified by `bus_sel`.
- `bus_rd`  in  1  read strobe; qualified by `bus_sel`.
- `bus_addr`  in  4  byte offset; only bits [3:2] are decoded.
- `bus_wdata`  in  32  write data.
- `bus_rdata`  out  32  read data; combinational from `bus_addr`.
- `exc_uart`  out  1  one-cycle interrupt pulse to the CSR file.

## Operation
Register map:
- 0x0 RXDATA (R):
  - Returns {24'b0, FIFO head}.
  - A read with the FIFO non-empty pops the FIFO.
  - A read with the FIFO empty returns 0 and pops nothing.
- 0x4 STATUS:
  - Bit 0: FIFO non-empty (RO).
  - Bit 1: FIFO full (RO).
  - Bit 2: overrun (sticky, write-1-to-clear).
  - Bit 3: framing error (sticky, write-1-to-clear).
  - Bit 4: parity error (W1C; present only with the macro, otherwise reads 0).
- 0x8 CTRL (RW): bit 0 `rx_en`, bit 1 `irq_en`; reset value 0.
- 0xC DIV (RW): bits [15:0] oversample divisor; reset value `DIV_RST`.
  - Writing 0 is treated as 1.

Receive path:
- `uart_rx` passes through a 2-FF synchronizer that resets to 1.
- The tick counter counts 0..DIV-1 and emits `tick` at DIV-1.
- A 4-bit sample counter advances on each `tick`.

Receiver FSM (states IDLE, START, DATA, PARITY (macro only), STOP):
- IDLE: on a synchronized low while `rx_en`=1, clear the sample counter → START.
- START: at sample count 7, still low → DATA; high → IDLE (glitch rejected).
- DATA:
  - Every 16 ticks, sample the bit into the shift register, LSB first.
  - After bit 7 → PARITY (macro) or STOP.
- STOP: sample after 16 ticks.
  - Sampled 1 → push the byte to the FIFO.
  - Sampled 0 → set the framing error and discard the byte.
  - Either way → IDLE.
- Clearing `rx_en` mid-frame forces IDLE and discards the partial byte.

FIFO:
- Head/tail pointers are log2(DEPTH)+1 bits wide; wrap is modulo 2·DEPTH.
- Full: MSBs differ and the low bits are equal. Empty: pointers are equal.
- Push while full: the byte is dropped and overrun is set.
- Simultaneous push and pop: both happen and the count is unchanged.
  - This also holds when full, so no overrun is raised in that case.

Interrupt:
- `exc_uart` = registered (push accepted & `irq_en`).
- It is a pulse, not a level, because the CSR file latches MIP stickily.

## Timing
- Reset (`rst`=0 at a `clk` edge):
  - FSM → IDLE; pointers and all flags → 0.
  - CTRL → 0; DIV → `DIV_RST`.
  - `exc_uart`=0; `bus_rdata` reflects the reset state.
- Reset mid-frame aborts the frame; nothing is pushed.
- `uart_rx` falling edge to IDLE exit: 2 cycles (synchronizer) plus 1 cycle.
- Stop-bit sample: the byte is visible in RXDATA on the next cycle.
  - `exc_uart` asserts in that same next cycle, for exactly 1 cycle.
- A pop takes effect at the clock edge ending the read cycle.
- A W1C write and a same-cycle error set: the set wins.
- Writing DIV restarts the tick counter at 0.

## Configuration
`UART_RX_PARITY_EN`:
- Defined:
  - Even-parity bit sampled in the PARITY state, 16 ticks after bit 7.
  - Parity mismatch sets STATUS[4]. The byte is still pushed if the stop bit is valid.
- Undefined: no PARITY state; 8N1 only; STATUS[4] reads 0.

## Structure
- Shared package additions:
  - `type_uart_rx_state_e` (receiver FSM states).
  - Register offset constants `UART_RXDATA`, `UART_STATUS`, `UART_CTRL`, `UART_DIV`.
  - `UART_IRQ_CODE` = 16, matching mcause 0x80000010.
- One sub-module: `uart_rx_fifo` (parameterised synchronous FIFO, push/pop/full/empty).

## Test plan
- DIV=1, `rx_en`=`irq_en`=1; send 0xA5:
  - RXDATA = 0x000000A5.
  - One `exc_uart` pulse 1 cycle after the stop sample.
  - STATUS = 0x1 before the read, 0x0 after.
- 8-cycle low glitch on `uart_rx` with DIV=1 (shorter than half a bit):
  - FSM returns to IDLE; no push, no pulse.
- Send 9 bytes 0x01..0x09 with `FIFO_DEPTH`=8:
  - STATUS[2:1] = 2'b11.
  - Reads return 0x01..0x08; the ninth byte is lost.
- Frame with stop bit 0 (data 0x3C):
  - STATUS[3]=1; FIFO stays empty.
  - Write STATUS=0x8 → STATUS[3]=0.
- `irq_en`=0; send 0x55:
  - Byte is stored; `exc_uart` stays 0.
- Under `UART_RX_PARITY_EN`, send 0x07 with parity bit 0:
  - STATUS[4]=1; RXDATA = 0x07.
